// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32IM pipe; strobes are combinational (0-cycle), state/counter registered.
// dmem busywait freezes everything; optional stall counter built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int MUL_LATENCY = 1,
    parameter int DIV_LATENCY = 33,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_busywait,
    input  logic        dmem_busywait,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_dest_addr,
    input  logic        ex_branch_taken,
    input  logic        ex_muldiv_valid,
    input  logic        ex_is_div,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        md_start,
    output logic        md_done,
    output logic [31:0] stall_cycles
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MUL_LAT = CNT_W'(MUL_LATENCY);
    localparam logic [CNT_W-1:0] DIV_LAT = CNT_W'(DIV_LATENCY);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] md_lat;
    logic             md_stall;
    logic             load_use;

    assign md_lat = ex_is_div ? DIV_LAT : MUL_LAT;

    assign load_use = ex_mem_read && (ex_dest_addr != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1_addr == ex_dest_addr)) ||
                       (id_uses_rs2 && (id_rs2_addr == ex_dest_addr)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Occupancy FSM: a frozen pipe (dmem busywait) holds state and counter untouched.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        md_stall  = 1'b0;
        md_start  = 1'b0;
        md_done   = 1'b0;
        if (rst && !dmem_busywait) begin
            case (state)
                RUN: begin
                    if (ex_muldiv_valid) begin
                        md_start = 1'b1;
                        if (md_lat > ONE) begin
                            md_stall  = 1'b1;
                            cnt_nxt   = md_lat - ONE;
                            state_nxt = MD_WAIT;
                        end else begin
                            md_done = 1'b1;
                        end
                    end
                end
                MD_WAIT: begin
                    if (cnt > ONE) begin
                        md_stall = 1'b1;
                        cnt_nxt  = cnt - ONE;
                    end else begin
                        md_done   = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Strobe priority: dmem freeze > mul/div stall > branch redirect > load-use > imem wait.
    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (rst && !dmem_busywait) begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (md_stall) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_flush = 1'b1;
            end else if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end else if (imem_busywait) begin
                pc_en       = 1'b0;
                if_id_flush = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (!pc_en && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = 32'h0;
`endif

endmodule
